// File: rtl/game_state_ctrl.sv
// game_state_ctrl
//   Frame-rate game sequencer sitting after the entity selector. Runs the
//   IDLE/READY/PLAY/DEATH/OVER/WIN flow, tracks lives, and drives freeze and
//   respawn to the movement blocks plus status flags to the HUD/colour mapper.
//
// Ports
//   Clk           system clock
//   Reset         synchronous, active-high reset
//   frame_tick    one-Clk pulse at start of vertical blank
//   lose_game     per-pixel Pac-Man/ghost overlap flag
//   pellets_left  pellets remaining, valid at frame_tick
//   start_key     start key level
//   state         IDLE=0 READY=1 PLAY=2 DEATH=3 OVER=4 WIN=5
//   lives         remaining lives
//   freeze        movement blocks hold positions
//   respawn       one-Clk pulse on entry into READY
//   flash         death blink
//   game_over     high in OVER
//   game_won      high in WIN
module game_state_ctrl #(
   parameter int unsigned LIVES_INIT   = 3,
   parameter int unsigned READY_FRAMES = 120,
   parameter int unsigned DEATH_FRAMES = 90,
   parameter int unsigned PELLET_W     = 9
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                frame_tick,
   input  logic                lose_game,
   input  logic [PELLET_W-1:0] pellets_left,
   input  logic                start_key,
   output logic [2:0]          state,
   output logic [1:0]          lives,
   output logic                freeze,
   output logic                respawn,
   output logic                flash,
   output logic                game_over,
   output logic                game_won
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_PLAY  = 3'd2,
      S_DEATH = 3'd3,
      S_OVER  = 3'd4,
      S_WIN   = 3'd5
   } state_t;

   localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
   localparam logic [7:0] READY_LAST = 8'(READY_FRAMES - 1);
   localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);

   state_t     cur, nxt;
   logic       start_q;
   logic       hit;
   logic [7:0] frame_cnt;

   logic       start_rise;
   logic       hit_now;
   logic       changed;
   logic [1:0] lives_nxt;
   logic [7:0] cnt_nxt;
   logic       hit_nxt;
   logic       respawn_nxt;
   logic       freeze_nxt;
   logic       flash_nxt;
   logic       over_nxt;
   logic       won_nxt;

   assign start_rise = start_key & ~start_q;
   // A collision in the same Clk as frame_tick still counts for this frame.
   assign hit_now    = hit | (lose_game & (cur == S_PLAY));

   always_comb begin
      nxt       = cur;
      lives_nxt = lives;
      case (cur)
         S_IDLE, S_OVER, S_WIN: begin
            if (start_rise) begin
               nxt       = S_READY;
               lives_nxt = LIVES_LOAD;
            end
         end
         S_READY: begin
            if (frame_tick && frame_cnt == READY_LAST)
               nxt = S_PLAY;
         end
         S_PLAY: begin
            if (frame_tick) begin
               if (pellets_left == '0) begin
                  nxt = S_WIN;
               end else if (hit_now) begin
                  nxt       = S_DEATH;
                  lives_nxt = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
               end
            end
         end
         S_DEATH: begin
            if (frame_tick && frame_cnt == DEATH_LAST)
               nxt = (lives == 2'd0) ? S_OVER : S_READY;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_comb begin
      changed     = (nxt != cur);
      cnt_nxt     = changed ? '0 : (frame_tick ? frame_cnt + 8'd1 : frame_cnt);
      hit_nxt     = (changed || frame_tick) ? 1'b0 : hit_now;
      // Outputs are registered, so they are derived from the next-state values.
      respawn_nxt = changed && (nxt == S_READY);
      freeze_nxt  = (nxt != S_PLAY);
      flash_nxt   = (nxt == S_DEATH) && cnt_nxt[3];
      over_nxt    = (nxt == S_OVER);
      won_nxt     = (nxt == S_WIN);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cur       <= S_IDLE;
         start_q   <= 1'b0;
         hit       <= 1'b0;
         frame_cnt <= '0;
         lives     <= '0;
         freeze    <= 1'b1;
         respawn   <= 1'b0;
         flash     <= 1'b0;
         game_over <= 1'b0;
         game_won  <= 1'b0;
      end else begin
         cur       <= nxt;
         start_q   <= start_key;
         hit       <= hit_nxt;
         frame_cnt <= cnt_nxt;
         lives     <= lives_nxt;
         freeze    <= freeze_nxt;
         respawn   <= respawn_nxt;
         flash     <= flash_nxt;
         game_over <= over_nxt;
         game_won  <= won_nxt;
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl
//   Directed bench for game_state_ctrl with hand-computed expectations.
//   Inputs are driven and outputs sampled on the falling edge of clk.
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       lose_game = 1'b0;
   logic [8:0] pellets_left = 9'd50;
   logic       start_key = 1'b0;
   logic [2:0] state;
   logic [1:0] lives;
   logic       freeze, respawn, flash, game_over, game_won;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   game_state_ctrl #(
      .LIVES_INIT(3),
      .READY_FRAMES(120),
      .DEATH_FRAMES(90),
      .PELLET_W(9)
   ) dut (
      .Clk(clk),
      .Reset(reset),
      .frame_tick(frame_tick),
      .lose_game(lose_game),
      .pellets_left(pellets_left),
      .start_key(start_key),
      .state(state),
      .lives(lives),
      .freeze(freeze),
      .respawn(respawn),
      .flash(flash),
      .game_over(game_over),
      .game_won(game_won)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One frame_tick pulse; returns at the falling edge after it was consumed.
   task automatic tick();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press and release start; returns with the READY entry visible.
   task automatic press_start();
      @(negedge clk) start_key = 1'b1;
      @(negedge clk) start_key = 1'b0;
   endtask

   task automatic lose_pulse();
      @(negedge clk) lose_game = 1'b1;
      @(negedge clk) lose_game = 1'b0;
   endtask

   int rsp_cnt;

   initial begin
      // reset state
      idle(3);
      check("rst_state", state, 0);
      check("rst_lives", lives, 0);
      check("rst_freeze", freeze, 1);
      check("rst_respawn", respawn, 0);
      check("rst_flash", flash, 0);
      check("rst_over", game_over, 0);
      check("rst_won", game_won, 0);
      @(negedge clk) reset = 1'b0;

      // start held 5 Clk -> single respawn pulse
      start_key = 1'b1;
      rsp_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (respawn) rsp_cnt++;
      end
      start_key = 1'b0;
      check("start_rsp_once", rsp_cnt, 1);
      check("start_state", state, 1);
      check("start_lives", lives, 3);
      check("ready_freeze", freeze, 1);

      ticks(119);
      check("ready_119", state, 1);
      tick();
      check("ready_120", state, 2);
      check("play_freeze", freeze, 0);

      // start ignored in PLAY
      press_start();
      idle(1);
      check("play_start_ign", state, 2);

      // death 1: mid-frame collision
      pellets_left = 9'd50;
      idle(1);
      lose_pulse();
      check("hit_wait_tick", state, 2);
      tick();
      check("death1_state", state, 3);
      check("death1_lives", lives, 2);
      check("death1_flash0", flash, 0);
      ticks(7);
      check("flash_t7", flash, 0);
      tick();
      check("flash_t8", flash, 1);
      lose_pulse();
      check("death_lose_ign", lives, 2);
      ticks(7);
      check("flash_t15", flash, 1);
      tick();
      check("flash_t16", flash, 0);
      ticks(73);
      check("death_89", state, 3);
      tick();
      check("death1_end", state, 1);
      check("death1_rsp", respawn, 1);
      idle(1);
      check("death1_rsp_end", respawn, 0);

      // lose_game in READY must not arm a hit
      lose_pulse();
      lose_pulse();
      check("ready_lose_lives", lives, 2);
      ticks(120);
      check("play2_state", state, 2);
      tick();
      check("play2_no_stale_hit", state, 2);

      // death 2: collision coincident with frame_tick
      @(negedge clk) begin frame_tick = 1'b1; lose_game = 1'b1; end
      @(negedge clk) begin frame_tick = 1'b0; lose_game = 1'b0; end
      check("death2_state", state, 3);
      check("death2_lives", lives, 1);
      ticks(90);
      check("death2_end", state, 1);
      ticks(120);

      // death 3 -> OVER
      lose_pulse();
      tick();
      check("death3_lives", lives, 0);
      ticks(90);
      check("over_state", state, 4);
      check("over_flag", game_over, 1);
      check("over_lives", lives, 0);
      check("over_rsp", respawn, 0);
      check("over_freeze", freeze, 1);
      press_start();
      check("over_restart", state, 1);
      check("over_relives", lives, 3);
      check("over_rsp_pulse", respawn, 1);
      check("over_clear", game_over, 0);

      // WIN beats a simultaneous hit
      ticks(120);
      lose_pulse();
      pellets_left = 9'd0;
      tick();
      check("win_state", state, 5);
      check("win_lives", lives, 3);
      check("win_flag", game_won, 1);
      check("win_freeze", freeze, 1);
      pellets_left = 9'd50;
      press_start();
      check("win_restart", state, 1);
      check("win_rsp", respawn, 1);

      // reset during DEATH frame 40
      ticks(120);
      lose_pulse();
      tick();
      check("death4_lives", lives, 2);
      ticks(40);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      check("midrst_state", state, 0);
      check("midrst_lives", lives, 0);
      check("midrst_freeze", freeze, 1);
      check("midrst_rsp", respawn, 0);
      check("midrst_flash", flash, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Frame-rate game controller directly downstream of the entity selector.
- Consumes the per-pixel lose_game collision flag, the remaining-pellet count and the start key.
- Runs the IDLE/READY/PLAY/DEATH/OVER/WIN sequence and tracks lives.
- Drives freeze and respawn controls back to the Pac-Man and ghost movement blocks.
- Drives status flags to the HUD/colour mapper.

Parameters:
- LIVES_INIT, 3, lives loaded on game start; 1..3.
- READY_FRAMES, 120, frame_ticks spent in READY before play starts; >=1.
- DEATH_FRAMES, 90, frame_ticks spent in DEATH animation; >=1.
- PELLET_W, 9, width of pellets_left.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-Clk pulse at start of vertical blank.
- lose_game  in  1  per-pixel Pac-Man/ghost overlap flag from entity selector.
- pellets_left  in  PELLET_W  pellets remaining; valid at frame_tick.
- start_key  in  1  level from keyboard decoder.
- state  out  3  IDLE=0, READY=1, PLAY=2, DEATH=3, OVER=4, WIN=5.
- lives  out  2  remaining lives.
- freeze  out  1  1 = movement blocks hold positions.
- respawn  out  1  one-Clk pulse; movement blocks reload start positions.
- flash  out  1  death blink for colour mapper.
- game_over  out  1  high in OVER.
- game_won  out  1  high in WIN.

Behaviour:
Clocking and reset:
- Single clock. Reset has priority over all other inputs.
- Reset values: state=IDLE, lives=0, freeze=1, respawn=0, flash=0, game_over=0, game_won=0, hit latch=0, frame_cnt=0, start edge register=0.
- Reset mid-game returns to IDLE on the next edge; a respawn pulse in flight is cancelled.

Input handling:
- start_key is edge-detected through one register. start_rise = start_key & ~start_q.
- Holding start_key produces exactly one event.
- Hit latch: set on any Clk with lose_game=1 while state=PLAY. Cleared on frame_tick (after being sampled), and on every state change.
- lose_game outside PLAY is ignored.

Frame counter:
- frame_cnt (8 bits) increments on frame_tick and clears on every state transition.

State machine (all outputs registered):
- IDLE: freeze=1. On start_rise: lives<=LIVES_INIT, pulse respawn, go to READY.
- READY: freeze=1. On frame_tick with frame_cnt==READY_FRAMES-1: go to PLAY.
- PLAY: freeze=0. Transitions are evaluated only on frame_tick:
  - pellets_left==0 -> WIN. WIN has priority over a simultaneous hit.
  - else hit latch=1 -> DEATH, lives<=lives-1.
  - else stay in PLAY.
  - A collision in the same Clk as frame_tick counts toward this frame's evaluation.
- DEATH: freeze=1; flash=frame_cnt[3].
  - On frame_tick with frame_cnt==DEATH_FRAMES-1:
    - lives==0 -> OVER.
    - else pulse respawn, go to READY.
  - flash=0 in all other states.
- OVER: game_over=1, freeze=1. On start_rise: reload lives, pulse respawn, go to READY.
- WIN: game_won=1, freeze=1. On start_rise: reload lives, pulse respawn, go to READY.

Output timing and widths:
- respawn is high for exactly the one Clk coincident with entry into READY.
- lives decrement saturates at 0; it never wraps.
- Undefined state encodings recover to IDLE.
- start_rise is ignored in READY, PLAY and DEATH.

Latency:
- State changes appear one Clk after the qualifying frame_tick or start_rise.

Test Plan:
- Reset, then start_key held high 5 Clk -> one respawn pulse, state=1, lives=3; state=2 exactly 120 frame_ticks later.
- In PLAY, lose_game pulsed 1 Clk mid-frame, pellets_left=50 -> on next frame_tick state=3, lives=2; flash toggles every 8 frame_ticks; after 90 ticks respawn pulses, state=1.
- Three deaths from LIVES_INIT=3 -> third DEATH ends in state=4, game_over=1, lives=0, no respawn; start_key -> state=1, lives=3, respawn pulse.
- lose_game and pellets_left=0 in the same frame -> state=5, lives unchanged, game_won=1.
- lose_game in the Clk coinciding with frame_tick -> DEATH taken that frame. lose_game asserted during READY/DEATH -> no effect, lives unchanged.
- Reset asserted during DEATH frame 40 -> next Clk state=0, lives=0, freeze=1, respawn=0.
